// File: rtl/sr_cmd_gen.sv
// -----------------------------------------------------------------------------
// sr_cmd_gen
//   Command stage in front of the lab SR flip-flop. Two raw push buttons
//   (set, reset) are each synchronised into the CLK domain and debounced with
//   a stable-count filter. A debounced rising edge becomes a one-cycle
//   S or R pulse. If both rise together, set wins, matching the set
//   priority of the downstream SR stage.
//
//   Parameters
//     DB_CYCLES : consecutive cycles the synchronised input must disagree with
//                 its debounced level before the level flips (1..2**CNT_W-1)
//     CNT_W     : width of each debounce counter
//
//   Ports
//     CLK         in  rising-edge clock
//     rst         in  asynchronous, active-low reset
//     btn_set     in  raw set button (asynchronous, bouncy)
//     btn_reset   in  raw reset button (asynchronous, bouncy)
//     S           out one-cycle set pulse
//     R           out one-cycle reset pulse (never together with S)
//     set_level   out debounced level of btn_set
//     reset_level out debounced level of btn_reset
//     conflict    out one-cycle flag: both debounced rises in the same cycle
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// sr_cmd_gen_db
//   One button channel: 2-flop synchroniser, stable-count debouncer and
//   rising-edge detector.
//
//   Ports
//     CLK   in  clock
//     rst   in  asynchronous, active-low reset
//     btn   in  raw button
//     level out debounced level
//     rise  out high for one cycle after level goes 0 -> 1
// -----------------------------------------------------------------------------
module sr_cmd_gen_db #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 3
) (
   input  logic CLK,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic rise
);

   // Terminal count: the DB_CYCLES-th consecutive disagreeing cycle flips the
   // level, so the counter tops out at DB_CYCLES-1 and can never wrap.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             level_d;
   logic [CNT_W-1:0] cnt;

   // NOTE: every register here is reset, including the synchroniser, so a
   // button held through reset must re-debounce from a known zero state.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
      end else begin
         // NOTE: non-blocking assignments make sync2 take the old sync1, which
         // is what builds the two-stage synchroniser.
         sync1   <= btn;
         sync2   <= sync1;
         level_d <= level;
         if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
               level <= ~level;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            // Any agreeing cycle restarts the stability count.
            cnt <= '0;
         end
      end
   end

   assign rise = level & ~level_d;

endmodule

module sr_cmd_gen #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 3
) (
   input  logic CLK,
   input  logic rst,
   input  logic btn_set,
   input  logic btn_reset,
   output logic S,
   output logic R,
   output logic set_level,
   output logic reset_level,
   output logic conflict
);

   logic rise_set;
   logic rise_reset;

   sr_cmd_gen_db #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
   ) u_db_set (
      .CLK   (CLK),
      .rst   (rst),
      .btn   (btn_set),
      .level (set_level),
      .rise  (rise_set)
   );

   sr_cmd_gen_db #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
   ) u_db_reset (
      .CLK   (CLK),
      .rst   (rst),
      .btn   (btn_reset),
      .level (reset_level),
      .rise  (rise_reset)
   );

   // Registered pulse outputs. Set wins a simultaneous request; the conflict
   // flag records that a reset request was dropped in that cycle.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         S        <= 1'b0;
         R        <= 1'b0;
         conflict <= 1'b0;
      end else begin
         S        <= rise_set;
         R        <= rise_reset & ~rise_set;
         conflict <= rise_set & rise_reset;
      end
   end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_gen
//   Directed bench for sr_cmd_gen with DB_CYCLES=4, CNT_W=3.
//   Inputs are driven at the falling edge; the following rising edge is
//   "edge e" of the scenario, and outputs are sampled at the next falling
//   edge ("after edge e"). Outputs are compared as the packed vector
//   {set_level, reset_level, S, R, conflict}.
// -----------------------------------------------------------------------------
module tb_sr_cmd_gen;

   logic CLK = 1'b0;
   logic rst;
   logic btn_set;
   logic btn_reset;
   logic S;
   logic R;
   logic set_level;
   logic reset_level;
   logic conflict;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   sr_cmd_gen #(
      .DB_CYCLES (4),
      .CNT_W     (3)
   ) dut (
      .CLK         (CLK),
      .rst         (rst),
      .btn_set     (btn_set),
      .btn_reset   (btn_reset),
      .S           (S),
      .R           (R),
      .set_level   (set_level),
      .reset_level (reset_level),
      .conflict    (conflict)
   );

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Held in reset with both buttons high: everything stays 0.
   task automatic test_reset();
      logic [4:0] got;
      rst       = 1'b0;
      btn_set   = 1'b1;
      btn_reset = 1'b1;
      for (int e = 0; e < 4; e++) begin
         tick();
         got = {set_level, reset_level, S, R, conflict};
         total++;
         if (got !== 5'b00000) begin
            bad++;
            $display("FAIL reset_hold e=%0d got=%b exp=%b", e, got, 5'b00000);
         end
      end
      btn_set   = 1'b0;
      btn_reset = 1'b0;
      tick();
      rst = 1'b1;
      for (int e = 0; e < 3; e++) begin
         tick();
         got = {set_level, reset_level, S, R, conflict};
         total++;
         if (got !== 5'b00000) begin
            bad++;
            $display("FAIL reset_idle e=%0d got=%b exp=%b", e, got, 5'b00000);
         end
      end
   endtask

   // Clean press: level after edge 5, S after edge 6 only; clean release
   // drops the level after edge 5 with no pulse.
   task automatic test_single_press();
      logic [4:0] got, exp;
      for (int e = 0; e < 9; e++) begin
         btn_set = 1'b1;
         tick();
         got = {set_level, reset_level, S, R, conflict};
         exp = {e >= 5, 1'b0, e == 6, 1'b0, 1'b0};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL press e=%0d got=%b exp=%b", e, got, exp);
         end
      end
      for (int e = 0; e < 8; e++) begin
         btn_set = 1'b0;
         tick();
         got = {set_level, reset_level, S, R, conflict};
         exp = {e < 5, 1'b0, 1'b0, 1'b0, 1'b0};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL press_release e=%0d got=%b exp=%b", e, got, exp);
         end
      end
   endtask

   // Reset button bounces 1,0,1,0,1,0 (captures at edges 0..5), then stays 1
   // from capture edge 6: level after edge 11, R after edge 12.
   task automatic test_bounce();
      logic [4:0] got, exp;
      for (int e = 0; e < 15; e++) begin
         btn_reset = (e < 6) ? ((e % 2) == 0) : 1'b1;
         tick();
         got = {set_level, reset_level, S, R, conflict};
         exp = {1'b0, e >= 11, 1'b0, e == 12, 1'b0};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL bounce e=%0d got=%b exp=%b", e, got, exp);
         end
      end
      for (int e = 0; e < 8; e++) begin
         btn_reset = 1'b0;
         tick();
         got = {set_level, reset_level, S, R, conflict};
         exp = {1'b0, e < 5, 1'b0, 1'b0, 1'b0};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL bounce_release e=%0d got=%b exp=%b", e, got, exp);
         end
      end
   endtask

   // Three-cycle glitch is one short of DB_CYCLES: no level, no pulse.
   task automatic test_glitch();
      logic [4:0] got;
      for (int e = 0; e < 12; e++) begin
         btn_set = (e < 3);
         tick();
         got = {set_level, reset_level, S, R, conflict};
         total++;
         if (got !== 5'b00000) begin
            bad++;
            $display("FAIL glitch e=%0d got=%b exp=%b", e, got, 5'b00000);
         end
      end
   endtask

   // Both rise together: S and conflict in the same cycle, R suppressed.
   task automatic test_simultaneous();
      logic [4:0] got, exp;
      for (int e = 0; e < 9; e++) begin
         btn_set   = 1'b1;
         btn_reset = 1'b1;
         tick();
         got = {set_level, reset_level, S, R, conflict};
         exp = {e >= 5, e >= 5, e == 6, 1'b0, e == 6};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL simul e=%0d got=%b exp=%b", e, got, exp);
         end
      end
      for (int e = 0; e < 8; e++) begin
         btn_set   = 1'b0;
         btn_reset = 1'b0;
         tick();
         got = {set_level, reset_level, S, R, conflict};
         exp = {e < 5, e < 5, 1'b0, 1'b0, 1'b0};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL simul_release e=%0d got=%b exp=%b", e, got, exp);
         end
      end
   endtask

   // Reset lands just after the level rose, when S was about to fire: the
   // pulse is lost, outputs clear immediately, and the held button
   // re-debounces from scratch after release.
   task automatic test_reset_mid();
      logic [4:0] got, exp;
      for (int e = 0; e < 6; e++) begin
         btn_set = 1'b1;
         tick();
         got = {set_level, reset_level, S, R, conflict};
         exp = {e >= 5, 1'b0, 1'b0, 1'b0, 1'b0};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL rstmid_pre e=%0d got=%b exp=%b", e, got, exp);
         end
      end
      rst = 1'b0;
      #1;
      got = {set_level, reset_level, S, R, conflict};
      total++;
      if (got !== 5'b00000) begin
         bad++;
         $display("FAIL rstmid_async got=%b exp=%b", got, 5'b00000);
      end
      for (int e = 0; e < 2; e++) begin
         tick();
         got = {set_level, reset_level, S, R, conflict};
         total++;
         if (got !== 5'b00000) begin
            bad++;
            $display("FAIL rstmid_hold e=%0d got=%b exp=%b", e, got, 5'b00000);
         end
      end
      rst = 1'b1;
      for (int e = 0; e < 9; e++) begin
         tick();
         got = {set_level, reset_level, S, R, conflict};
         exp = {e >= 5, 1'b0, e == 6, 1'b0, 1'b0};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL rstmid_post e=%0d got=%b exp=%b", e, got, exp);
         end
      end
      btn_set = 1'b0;
      repeat (8) tick();
   endtask

   // Hold 20 captures, release 10, press again: exactly two S pulses and a
   // silent fall of set_level after edge 25.
   task automatic test_hold_release();
      logic [4:0] got, exp;
      int pulses = 0;
      for (int e = 0; e < 46; e++) begin
         btn_set = (e < 20) || (e >= 30);
         tick();
         if (S === 1'b1) pulses++;
         got = {set_level, reset_level, S, R, conflict};
         exp = {(e >= 5 && e < 25) || e >= 35, 1'b0, e == 6 || e == 36,
                1'b0, 1'b0};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL hold e=%0d got=%b exp=%b", e, got, exp);
         end
      end
      total++;
      if (pulses !== 2) begin
         bad++;
         $display("FAIL hold_pulse_count got=%0d exp=%0d", pulses, 2);
      end
      btn_set = 1'b0;
      repeat (8) tick();
   endtask

   initial begin
      rst       = 1'b0;
      btn_set   = 1'b0;
      btn_reset = 1'b0;
      test_reset();
      test_single_press();
      test_bounce();
      test_glitch();
      test_simultaneous();
      test_reset_mid();
      test_hold_release();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
